// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the 8-bit ALU stage and the result FIFO behind it.
//   alu_op_e       : 3-bit opcode that produced a result (also the FIFO tag)
//   DATA_W, TAG_W  : default result and tag widths
//   result_entry_t : one buffered entry, {tag, data}
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int TAG_W  = 3;

  // Opcode encodings as produced by the ALU stage.
  typedef enum logic [TAG_W-1:0] {
    ALU_ADD    = 3'b000,  // a + b
    ALU_SUB_AB = 3'b001,  // a - b
    ALU_SUB_BA = 3'b010,  // b - a
    ALU_MUL    = 3'b011,  // a * b
    ALU_AND    = 3'b100,  // a & b
    ALU_DIV_AB = 3'b101,  // a / b
    ALU_DIV_BA = 3'b110,  // b / a
    ALU_OR     = 3'b111   // a | b
  } alu_op_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } result_entry_t;

  // Packs a result and its opcode into one entry.
  function automatic result_entry_t pack_entry(input logic [TAG_W-1:0] tag,
                                               input logic [DATA_W-1:0] data);
    result_entry_t e;
    e.tag  = tag;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/alu_fifo_mem.sv
// alu_fifo_mem
// DEPTH x WIDTH register array: one synchronous write port, one
// asynchronous (combinational) read port. Contents are not reset.
//   clk     : write clock, rising edge
//   wr_en   : write wr_data into entry wr_addr at the next edge
//   wr_addr : write index
//   wr_data : write value
//   rd_addr : read index
//   rd_data : current contents of entry rd_addr
module alu_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next contents: only the addressed entry changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d[wr_addr] = mem_q[wr_addr];
    end
  end

  // Storage register; deliberately has no reset, the pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
// Buffers ALU results (data + opcode tag) for a slow consumer. The ALU cannot
// stall, so a result arriving while full is dropped and recorded in a sticky
// overflow flag.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   clear      : synchronous flush of entries and overflow, beats push/pop
//   in_valid   : result valid; in_data/in_tag carry it
//   in_ready   : not full
//   out_valid  : head entry present; out_data/out_tag/out_zero describe it
//   out_ready  : consumer takes the head entry
//   count      : occupancy 0..DEPTH
//   overflow   : at least one result was dropped since rst/clear
module alu_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  import alu_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TAG_W + DATA_W;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push_s;
  logic          pop_s;
  logic          wr_en_s;
  logic [EW-1:0] rd_entry_s;

  // Status comes straight from registers: no path from in_valid/out_ready.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != {CW{1'b0}});
  assign count     = count_q;
  assign overflow  = overflow_q;

  assign push_s  = in_valid && in_ready;
  assign pop_s   = out_valid && out_ready;
  // A push in a clear cycle must not land in storage either.
  assign wr_en_s = push_s && !clear;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      count_d    = {CW{1'b0}};
      overflow_d = 1'b0;
    end else begin
      // Pointers are AW bits wide and DEPTH is a power of two, so +1 wraps.
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // Dropped while full, even if the head is popped this same cycle.
      if (in_valid && !in_ready) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // Control registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  alu_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_q),
    .wr_data ({in_tag, in_data}),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry_s)
  );

  assign out_data = rd_entry_s[DATA_W-1:0];
  assign out_tag  = rd_entry_s[EW-1:DATA_W];
  // Forced low when empty so stale storage never reports a zero result.
  assign out_zero = out_valid && (out_data == {DATA_W{1'b0}});

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [2:0] in_tag = 3'b000;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] out_tag;
  logic       out_zero;
  logic [2:0] count;
  logic       overflow;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: a plain queue of entries plus a sticky flag.
  result_entry_t mq[$];
  bit m_ovf = 1'b0;

  alu_result_fifo #(.DEPTH(DEPTH), .DATA_W(8), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_zero(out_zero), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Applies the buffer rules to the model using the inputs about to be clocked.
  task automatic model_edge();
    bit full;
    bit mpop;
    bit mpush;
    full  = (mq.size() == DEPTH);
    mpop  = (mq.size() != 0) && out_ready;
    mpush = in_valid && !full;
    if (clear) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (in_valid && full) m_ovf = 1'b1;
      if (mpop) void'(mq.pop_front());
      if (mpush) mq.push_back(pack_entry(in_tag, in_data));
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] t);
    in_valid = 1'b1; in_data = d; in_tag = t;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_power_on();
    #2;
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0 || out_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL power_on: count=%0d ov=%b ir=%b of=%b oz=%b, required 0 0 1 0 0", count, out_valid, in_ready, overflow, out_zero);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    do_clear();
    push(8'h11, 3'b000); push(8'h22, 3'b001); push(8'h33, 3'b010);
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++; $display("FAIL reset_precount: count=%0d, required 3", count);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0 || out_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: count=%0d ov=%b ir=%b of=%b oz=%b, required 0 0 1 0 0", count, out_valid, in_ready, overflow, out_zero);
    end
    #1;
    rst = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    cycle();
  endtask

  task automatic test_ordering();
    logic [7:0] vd [3];
    logic [2:0] vt [3];
    logic [2:0] ec;
    vd[0] = 8'h07; vd[1] = 8'hF1; vd[2] = 8'h00;
    vt[0] = ALU_ADD; vt[1] = ALU_SUB_AB; vt[2] = ALU_AND;
    do_clear();
    for (int i = 0; i < 3; i++) push(vd[i], vt[i]);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ec = 3'(3 - i);
      n_checks++;
      if (count !== ec || out_valid !== 1'b1 || out_data !== vd[i] || out_tag !== vt[i] || out_zero !== (vd[i] == 8'h00)) begin
        n_fail++;
        $display("FAIL ordering[%0d]: count=%0d data=%h tag=%b zero=%b, required %0d %h %b %b", i, count, out_data, out_tag, out_zero, ec, vd[i], vt[i], vd[i] == 8'h00);
      end
      cycle();
    end
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_zero !== 1'b0) begin
      n_fail++; $display("FAIL ordering_empty: count=%0d ov=%b oz=%b, required 0 0 0", count, out_valid, out_zero);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_drop();
    logic [7:0] vd [5];
    do_clear();
    for (int i = 0; i < 5; i++) begin
      vd[i] = 8'($urandom_range(1, 255));
      push(vd[i], 3'(i));
    end
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL full_state: count=%0d ir=%b of=%b, required 4 0 1", count, in_ready, overflow);
    end
    // Full with a simultaneous pop: the incoming result is still dropped.
    in_valid = 1'b1; in_data = 8'h5A; in_tag = 3'b111; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd3 || overflow !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_pop_drop: count=%0d of=%b ir=%b, required 3 1 1", count, overflow, in_ready);
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== vd[i] || out_tag !== 3'(i)) begin
        n_fail++; $display("FAIL full_drain[%0d]: ov=%b data=%h tag=%b, required 1 %h %b", i, out_valid, out_data, out_tag, vd[i], 3'(i));
      end
      cycle();
    end
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL full_after: ov=%b count=%0d of=%b, required 0 0 1", out_valid, count, overflow);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    result_entry_t sent[$];
    int nread;
    do_clear();
    for (int i = 0; i < 2; i++) begin
      sent.push_back(pack_entry(3'(i), 8'(8'h40 + i)));
      push(8'(8'h40 + i), 3'(i));
    end
    nread = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_data = 8'($urandom); in_tag = 3'($urandom);
      sent.push_back(pack_entry(in_tag, in_data));
      n_checks++;
      if (count !== 3'd2 || overflow !== 1'b0 || out_data !== sent[nread].data || out_tag !== sent[nread].tag) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: count=%0d of=%b data=%h tag=%b, required 2 0 %h %b", i, count, overflow, out_data, out_tag, sent[nread].data, sent[nread].tag);
      end
      nread++;
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [7:0] vd [4];
    do_clear();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        vd[i] = 8'($urandom);
        push(vd[i], 3'(r + i));
        n_checks++;
        if (count !== 3'(i + 1)) begin
          n_fail++; $display("FAIL wrap_fill r%0d[%0d]: count=%0d, required %0d", r, i, count, i + 1);
        end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (out_data !== vd[i] || out_tag !== 3'(r + i) || count !== 3'(4 - i)) begin
          n_fail++;
          $display("FAIL wrap_drain r%0d[%0d]: data=%h tag=%b count=%0d, required %h %b %0d", r, i, out_data, out_tag, count, vd[i], 3'(r + i), 4 - i);
        end
        cycle();
      end
      out_ready = 1'b0;
      n_checks++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL wrap_empty r%0d: count=%0d ov=%b, required 0 0", r, count, out_valid);
      end
    end
  endtask

  task automatic test_clear();
    do_clear();
    for (int i = 0; i < 5; i++) push(8'(8'h90 + i), 3'(i));
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd3 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL clear_setup: count=%0d of=%b, required 3 1", count, overflow);
    end
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_tag = 3'b101; out_ready = 1'b1;
    cycle();
    idle_inputs();
    n_checks++;
    if (count !== 3'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL clear_result: count=%0d of=%b ov=%b ir=%b, required 0 0 0 1", count, overflow, out_valid, in_ready);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL clear_absent: ov=%b count=%0d, required 0 0", out_valid, count);
    end
  endtask

  task automatic test_random();
    int ec;
    do_clear();
    for (int i = 0; i < 400; i++) begin
      clear     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 45);
      in_data   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      in_tag    = 3'($urandom);
      cycle();
      ec = mq.size();
      n_checks++;
      if (count !== ec[2:0] || in_ready !== (ec != DEPTH) || out_valid !== (ec != 0) || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL random_status[%0d]: count=%0d ir=%b ov=%b of=%b, required %0d %b %b %b", i, count, in_ready, out_valid, overflow, ec, ec != DEPTH, ec != 0, m_ovf);
      end
      n_checks++;
      if (ec == 0) begin
        if (out_zero !== 1'b0) begin
          n_fail++; $display("FAIL random_zero_empty[%0d]: out_zero=%b, required 0", i, out_zero);
        end
      end else if (out_data !== mq[0].data || out_tag !== mq[0].tag || out_zero !== (mq[0].data == 8'h00)) begin
        n_fail++;
        $display("FAIL random_head[%0d]: data=%h tag=%b zero=%b, required %h %b %b", i, out_data, out_tag, out_zero, mq[0].data, mq[0].tag, mq[0].data == 8'h00);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_power_on();
    test_reset();
    test_ordering();
    test_full_drop();
    test_back_to_back();
    test_wrap();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
